// File: rtl/counter_ctrl_pkg.sv
// Shared encodings and defaults for the counter sequencing controller.
package counter_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_START  = 2'd0,
        OP_STOP   = 2'd1,
        OP_RESUME = 2'd2,
        OP_CLEAR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/counter_ctrl_dp.sv
// Counter datapath: count and limit registers, incrementer and terminal compare.
module counter_ctrl_dp
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             load_limit,
    input  logic [WIDTH-1:0] limit_in,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] nxt;

    // Modulo-2^WIDTH increment; limit==0 therefore terminates on the wrap to 0.
    assign nxt   = count_q + WIDTH'(1);
    assign term  = (nxt == limit_q);
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            limit_q <= '0;
        end else begin
            if (load_limit) begin
                limit_q <= limit_in;
            end
            if (clr) begin
                count_q <= '0;
            end else if (inc) begin
                count_q <= nxt;
            end
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven sequencer for the up-counter: start/stop/resume/clear with
// one-shot or auto-reload terminal handling and a registered done pulse.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_auto,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             busy,
    output logic             done
);

    state_e state_q;
    state_e state_d;
    logic   auto_q;
    logic   auto_d;
    logic   done_d;
    logic   ready_d;
    logic   accept;
    logic   clr;
    logic   inc;
    logic   load_limit;
    logic   term;
    op_e    op;

    assign op     = op_e'(cmd_op);
    assign accept = cmd_valid && cmd_ready;

    counter_ctrl_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .inc        (inc),
        .load_limit (load_limit),
        .limit_in   (cmd_data),
        .count      (count),
        .term       (term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            auto_q    <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            auto_q    <= auto_d;
            done      <= done_d;
            cmd_ready <= ready_d;
        end
    end

    // Accepted commands win over a same-cycle tick, which is then dropped.
    always_comb begin
        state_d    = state_q;
        auto_d     = auto_q;
        done_d     = 1'b0;
        ready_d    = ~accept;
        clr        = 1'b0;
        inc        = 1'b0;
        load_limit = 1'b0;

        if (accept) begin
            case (op)
                OP_START: begin
                    load_limit = 1'b1;
                    auto_d     = cmd_auto;
                    clr        = 1'b1;
                    state_d    = ST_RUN;
                end
                OP_STOP: begin
                    if (state_q == ST_RUN) begin
                        state_d = ST_PAUSE;
                    end
                end
                OP_RESUME: begin
                    if (state_q == ST_PAUSE) begin
                        state_d = ST_RUN;
                    end
                end
                OP_CLEAR: begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                end
            endcase
        end else if ((state_q == ST_RUN) && tick) begin
            // One-shot terminal lands on count==limit, which is just nxt.
            if (term) begin
                done_d = 1'b1;
                if (auto_q) begin
                    clr = 1'b1;
                end else begin
                    inc     = 1'b1;
                    state_d = ST_DONE;
                end
            end else begin
                inc = 1'b1;
            end
        end
    end

    assign state = state_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random traffic, checked every
// cycle against a behavioural model.
module tb_counter_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int MODV = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_auto;
    logic             tick;
    logic [WIDTH-1:0] count;
    logic [1:0]       state;
    logic             busy;
    logic             done;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state
    int m_count, m_limit, m_auto, m_state, m_ready, m_done;
    bit chk = 1'b0;

    counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_auto  (cmd_auto),
        .tick      (tick),
        .count     (count),
        .state     (state),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, evaluated on the same edge the DUT samples.
    always @(posedge clk) begin
        if (rst) begin
            m_count = 0; m_limit = 0; m_auto = 0;
            m_state = 0; m_ready = 1; m_done = 0;
            chk = 1'b1;
        end else begin
            bit acc;
            acc = cmd_valid && (m_ready == 1);
            m_done = 0;
            m_ready = acc ? 0 : 1;
            if (acc) begin
                case (int'(cmd_op))
                    0: begin m_limit = int'(cmd_data); m_auto = int'(cmd_auto); m_count = 0; m_state = 1; end
                    1: if (m_state == 1) m_state = 2;
                    2: if (m_state == 2) m_state = 1;
                    default: begin m_count = 0; m_state = 0; end
                endcase
            end else if (m_state == 1 && tick) begin
                if ((m_count + 1) % MODV == m_limit) begin
                    m_done = 1;
                    if (m_auto != 0) m_count = 0;
                    else begin m_count = m_limit; m_state = 3; end
                end else begin
                    m_count = (m_count + 1) % MODV;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk) begin
            check("count", int'(count), m_count);
            check("state", int'(state), m_state);
            check("busy", int'(busy), (m_state == 1 || m_state == 2) ? 1 : 0);
            check("done", int'(done), m_done);
            check("cmd_ready", int'(cmd_ready), m_ready);
        end
    end

    task automatic cyc(input logic v, input logic [1:0] op, input logic [7:0] d,
                       input logic a, input logic t);
        cmd_valid = v; cmd_op = op; cmd_data = d; cmd_auto = a; tick = t;
        @(negedge clk);
        cmd_valid = 1'b0; tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 8'd0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0; cmd_auto = 1'b0; tick = 1'b0;
        cyc(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_state", int'(state), 0);
        check("rst_count", int'(count), 0);

        // Reset mid-run overrides a command and tick in the same cycle
        cyc(1'b1, 2'd0, 8'd5, 1'b0, 1'b0);
        ticks(3);
        check("midrun_count", int'(count), 3);
        rst = 1'b1;
        cyc(1'b1, 2'd0, 8'd9, 1'b0, 1'b1);
        rst = 1'b0;
        check("rstrun_count", int'(count), 0);
        check("rstrun_state", int'(state), 0);
        check("rstrun_done", int'(done), 0);
        check("rstrun_ready", int'(cmd_ready), 1);

        // One-shot limit 3
        cyc(1'b1, 2'd0, 8'd3, 1'b0, 1'b0);
        ticks(2);
        check("os_count2", int'(count), 2);
        check("os_model2", m_count, 2);
        ticks(1);
        check("os_count3", int'(count), 3);
        check("os_done", int'(done), 1);
        check("os_state", int'(state), 3);
        ticks(2);
        check("os_hold", int'(count), 3);
        check("os_done_once", int'(done), 0);

        // Auto-reload limit 4
        cyc(1'b1, 2'd0, 8'd4, 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            ticks(1);
            check("ar_count", int'(count), i % 4);
            check("ar_done", int'(done), (i % 4 == 0) ? 1 : 0);
            check("ar_state", int'(state), 1);
        end

        // Pause / resume, limit 10
        cyc(1'b1, 2'd0, 8'd10, 1'b0, 1'b0);
        ticks(2);
        cyc(1'b1, 2'd1, 8'd0, 1'b0, 1'b0);
        check("pr_ready_stop", int'(cmd_ready), 0);
        check("pr_paused", int'(state), 2);
        ticks(5);
        check("pr_hold", int'(count), 2);
        cyc(1'b1, 2'd2, 8'd0, 1'b0, 1'b0);
        check("pr_ready_resume", int'(cmd_ready), 0);
        check("pr_running", int'(state), 1);
        ticks(7);
        check("pr_count9", int'(count), 9);
        ticks(1);
        check("pr_count10", int'(count), 10);
        check("pr_done", int'(done), 1);
        check("pr_model_done", m_done, 1);

        // Collision: START with a would-be terminal tick
        cyc(1'b1, 2'd0, 8'd7, 1'b0, 1'b0);
        ticks(6);
        check("col_count6", int'(count), 6);
        cyc(1'b1, 2'd0, 8'd2, 1'b0, 1'b1);
        check("col_nodone", int'(done), 0);
        check("col_count0", int'(count), 0);
        ticks(2);
        check("col_done", int'(done), 1);
        check("col_count2", int'(count), 2);

        // Full wrap with limit 0
        cyc(1'b1, 2'd0, 8'd0, 1'b0, 1'b0);
        ticks(255);
        check("wrap_255", int'(count), 255);
        check("wrap_run", int'(state), 1);
        ticks(1);
        check("wrap_0", int'(count), 0);
        check("wrap_state", int'(state), 3);
        check("wrap_done", int'(done), 1);

        // Random traffic, small limits favoured so terminals occur often
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            cyc($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6)),
                1'($urandom), $urandom_range(0, 3) != 0);
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Sequencing controller for the up-counter datapath: starts, pauses, resumes and clears an enable-gated WIDTH-bit counter in response to a valid/ready command port.
- Counts external tick strobes up to a programmable terminal value; one-shot or auto-reload mode.
- Sits between a host/CSR command source and the counter; `done` feeds interrupt or sequencing logic downstream.

Parameters:
- WIDTH, 8, counter, limit and cmd_data width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_op  in  2  0=START, 1=STOP, 2=RESUME, 3=CLEAR.
- cmd_data  in  WIDTH  terminal value (limit); used by START only.
- cmd_auto  in  1  auto-reload mode; sampled by START only.
- tick  in  1  count strobe (one increment per high cycle while running).
- count  out  WIDTH  current count.
- state  out  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DONE.
- busy  out  1  state is RUN or PAUSE.
- done  out  1  one-cycle pulse on terminal count.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, count=0, limit=0, auto=0, done=0, cmd_ready=1 the cycle after rst deasserts. Reset overrides everything, including a command or tick in the same cycle.
- Handshake: a command is accepted when cmd_valid && cmd_ready at a rising edge. It takes effect at that edge, so state and count change at T+1. cmd_ready is 0 for exactly the one cycle after an acceptance and 1 otherwise. Maximum rate is one command per 2 cycles. cmd_valid held while cmd_ready=0 is not accepted and not lost.
- START (any state): limit<=cmd_data, auto<=cmd_auto, count<=0, state<=RUN.
- CLEAR (any state): count<=0, state<=IDLE; limit and auto are kept.
- STOP: RUN->PAUSE, count holds. Accepted as a no-op in IDLE, PAUSE and DONE.
- RESUME: PAUSE->RUN, count holds. Accepted as a no-op in IDLE, RUN and DONE.
- Counting, only in RUN with tick=1 and no command accepted that cycle:
  - nxt = count+1 mod 2^WIDTH.
  - Terminal when nxt==limit.
  - Non-terminal: count<=nxt.
  - Terminal, auto=0: count<=limit, state<=DONE, done=1 at T+1.
  - Terminal, auto=1: count<=0, state stays RUN, done=1 at T+1.
- limit==0: terminal after 2^WIDTH ticks. count returns to 0 in both modes, so it wraps without overflow error.
- limit==1: terminal on the first tick.
- Ticks in IDLE, PAUSE and DONE are ignored.
- A command accepted in the same cycle as a tick takes priority. The tick is dropped, and no done is raised even if that tick would have been terminal.
- done is registered: high exactly one cycle per terminal event, never asserted in the cycle after reset. busy and state are combinational decodes of the state register.

Decomposition:
- Package counter_ctrl_pkg:
  - op encodings OP_START/OP_STOP/OP_RESUME/OP_CLEAR (2-bit).
  - state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE (2-bit).
  - default WIDTH constant.
- Sub-module counter_ctrl_dp: count register + incrementer + terminal compare. Inputs are clr, inc and load_limit controls from the FSM; output is the `term` flag.
- FSM, handshake and done register live in counter_ctrl.

Test Plan:
- Reset mid-run: START limit=5 and 3 ticks, then rst=1 for one cycle with cmd_valid=1 and tick=1. Required: count=0, state=IDLE, done=0, cmd_ready=1 the following cycle.
- One-shot: START limit=3 auto=0, ticks every cycle. Required: count 1,2,3, done pulses once with count=3, state=DONE. Further ticks leave count at 3.
- Auto-reload: START limit=4 auto=1, 12 consecutive ticks. Required: count 1,2,3,0 repeating, done pulses 3 times spaced 4 cycles apart, state stays RUN.
- Pause/resume: START limit=10, 2 ticks, STOP, 5 ticks, RESUME, 8 ticks. Required: count holds at 2 in PAUSE, done fires when count reaches 10. cmd_ready is low the cycle after each accept.
- Collision: RUN at count=6 with limit=7, START limit=2 accepted together with tick. Required: no done, count=0, limit=2. Two more ticks then give done.
- Full wrap: START limit=0 auto=0, 256 ticks. Required: count reaches 255, then the 256th tick sets count=0, state=DONE, done=1.
